// File: rtl/pit_bus_seq_if.sv
// Request/response handshake between a host and the pit_bus_seq 8254 bus sequencer.
// The host side uses the master modport and the sequencer uses the slave modport.
interface pit_bus_seq_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_op;
    logic [1:0]  req_ch;
    logic [1:0]  req_rw;
    logic [2:0]  req_mode;
    logic        req_bcd;
    logic [15:0] req_count;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_err;

    modport master (
        output req_valid, req_op, req_ch, req_rw, req_mode, req_bcd, req_count,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_ch, req_rw, req_mode, req_bcd, req_count,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/pit_bus_seq.sv
// Turns one-shot program/read counter requests into 8254 control-word and data-byte
// bus cycles (setup, strobe, hold, gap), ending each transaction with a response pulse.
module pit_bus_seq #(
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned HOLD_CYC   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    pit_bus_seq_if.slave bus,
    output logic [7:0]  pit_di_o,
    input  logic [7:0]  pit_do_i,
    output logic        pit_cs_n_o,
    output logic        pit_rd_n_o,
    output logic        pit_wr_n_o,
    output logic [1:0]  pit_a_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_GAP, S_RESP
    } state_t;

    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        alive_q;
    logic        op_q, op_d;
    logic [1:0]  ch_q, ch_d;
    logic [1:0]  rw_q, rw_d;
    logic [2:0]  mode_q, mode_d;
    logic        bcd_q, bcd_d;
    logic [15:0] count_q, count_d;
    logic [2:0]  mask_q, mask_d;
    logic [1:0]  cur_q, cur_d;
    logic        err_q, err_d;
    logic [15:0] data_q, data_d;
    logic [7:0]  di_q, di_d;

    logic        in_acc;
    logic        is_rd;
    logic [1:0]  rw_eff;
    logic [2:0]  rem;

    // Byte driven on Di for access idx: 0 = control word / latch command, 1 = LSB, 2 = MSB.
    function automatic logic [7:0] acc_byte(input logic op, input logic [1:0] ch,
                                            input logic [1:0] rw, input logic [2:0] mode,
                                            input logic bcd, input logic [15:0] count,
                                            input logic [1:0] idx);
        if (idx == 2'd0)      return op ? {ch, 6'b0} : {ch, rw, mode, bcd};
        else if (idx == 2'd1) return count[7:0];
        else                  return count[15:8];
    endfunction

    assign in_acc = (state_q == S_SETUP) || (state_q == S_STROBE) || (state_q == S_HOLD);
    assign is_rd  = op_q && (cur_q != 2'd0);
    assign rw_eff = (bus.req_op && bus.req_rw == 2'b00) ? 2'b11 : bus.req_rw;
    assign rem    = mask_q & ~(3'b001 << cur_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            alive_q <= 1'b0;
            op_q    <= 1'b0;
            ch_q    <= '0;
            rw_q    <= '0;
            mode_q  <= '0;
            bcd_q   <= 1'b0;
            count_q <= '0;
            mask_q  <= '0;
            cur_q   <= '0;
            err_q   <= 1'b0;
            data_q  <= '0;
            di_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            alive_q <= 1'b1;
            op_q    <= op_d;
            ch_q    <= ch_d;
            rw_q    <= rw_d;
            mode_q  <= mode_d;
            bcd_q   <= bcd_d;
            count_q <= count_d;
            mask_q  <= mask_d;
            cur_q   <= cur_d;
            err_q   <= err_d;
            data_q  <= data_d;
            di_q    <= di_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        ch_d    = ch_q;
        rw_d    = rw_q;
        mode_d  = mode_q;
        bcd_d   = bcd_q;
        count_d = count_q;
        mask_d  = mask_q;
        cur_d   = cur_q;
        err_d   = err_q;
        data_d  = data_q;
        di_d    = di_q;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid && alive_q) begin
                    op_d    = bus.req_op;
                    ch_d    = bus.req_ch;
                    rw_d    = bus.req_rw;
                    mode_d  = bus.req_mode;
                    bcd_d   = bus.req_bcd;
                    count_d = bus.req_count;
                    data_d  = '0;
                    cur_d   = 2'd0;
                    err_d   = (bus.req_ch == 2'd3);
                    if (bus.req_ch == 2'd3) begin
                        state_d = S_RESP;
                    end else begin
                        mask_d  = {rw_eff, 1'b1};
                        cnt_d   = SETUP_LD;
                        di_d    = acc_byte(bus.req_op, bus.req_ch, bus.req_rw, bus.req_mode,
                                           bus.req_bcd, bus.req_count, 2'd0);
                        state_d = S_SETUP;
                    end
                end
            end
            S_SETUP: begin
                if (cnt_q == 4'd0) begin
                    cnt_d   = STROBE_LD;
                    state_d = S_STROBE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_STROBE: begin
                if (cnt_q == 4'd0) begin
                    // Do is captured on the edge that ends the strobe, while RD is still low.
                    if (is_rd && cur_q == 2'd1) data_d[7:0]  = pit_do_i;
                    if (is_rd && cur_q == 2'd2) data_d[15:8] = pit_do_i;
                    cnt_d   = HOLD_LD;
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_HOLD: begin
                if (cnt_q == 4'd0) begin
                    mask_d = rem;
                    if (rem == 3'b000) begin
                        state_d = S_RESP;
                    end else begin
                        cur_d   = rem[1] ? 2'd1 : 2'd2;
                        state_d = S_GAP;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_GAP: begin
                cnt_d   = SETUP_LD;
                state_d = S_SETUP;
                if (!op_q) di_d = acc_byte(op_q, ch_q, rw_q, mode_q, bcd_q, count_q, cur_q);
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus pins decode straight from state so an asynchronous reset releases them at once.
    assign pit_cs_n_o = !in_acc;
    assign pit_a_o    = in_acc ? ((cur_q == 2'd0) ? 2'b11 : ch_q) : 2'b00;
    assign pit_wr_n_o = !((state_q == S_STROBE) && !is_rd);
    assign pit_rd_n_o = !((state_q == S_STROBE) && is_rd);
    assign pit_di_o   = di_q;

    assign bus.req_ready = (state_q == S_IDLE) && alive_q;
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_err   = (state_q == S_RESP) && err_q;
    assign bus.rsp_data  = data_q;

endmodule
